// File: rtl/var_delay_line_if.sv
// Sample bus for var_delay_line: input sample in, delayed sample out.
// master drives in_valid/in_data and observes the delayed sample;
// slave is the delay line itself.
interface var_delay_line_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic [NCH*WIDTH-1:0] out_data;

    modport master (output in_valid, in_data, input  out_valid, out_data);
    modport slave  (input  in_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/var_delay_line.sv
// var_delay_line: NCH x WIDTH runtime-programmable delay line built on a
// MAX_DEPTH-entry circular buffer. An input sample reappears D cycles later,
// where D = clamp(dly_q, 1, MAX_DEPTH). A flush, or any change of D, drops
// every in-flight sample and raises busy for D cycles while the line refills.
// Optional build macro VAR_DELAY_LINE_CNT_EN adds out_cnt, a saturating count
// of cycles with out_valid=1.

// Per-channel data storage. Data is never reset; the shared valid bits
// decide whether a stored word is visible.
module var_delay_line_lane #(
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = 16,
    parameter int AW        = 4
) (
    input  logic             clk,
    input  logic [AW-1:0]    wp,
    input  logic [AW-1:0]    rp,
    input  logic [WIDTH-1:0] din,
    input  logic             en_out,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [MAX_DEPTH];

    // write the current sample into the slot under the write pointer
    always_ff @(posedge clk) begin
        mem[wp] <= din;
    end

    assign dout = en_out ? mem[rp] : '0;
endmodule

module var_delay_line #(
    parameter int NCH       = 2,
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = 16,
    // derived from MAX_DEPTH; leave at default
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef VAR_DELAY_LINE_CNT_EN
    output logic [31:0]     out_cnt,
`endif
    input  logic            flush,
    input  logic [DW-1:0]   dly,
    var_delay_line_if.slave bus,
    output logic            busy
);
    localparam int AW = $clog2(MAX_DEPTH);
    localparam int XW = DW + 1;   // room for wp + MAX_DEPTH before wrapping

    typedef enum logic {IDLE, REFILL} state_t;

    logic [DW-1:0]              dly_q;
    logic [DW-1:0]              d_cur;
    logic [DW-1:0]              d_prev;
    logic [DW-1:0]              cnt;
    logic [AW-1:0]              wp;
    logic [AW-1:0]              wp_nxt;
    logic [AW-1:0]              rp;
    logic [XW-1:0]              rp_x;
    logic                       rp_unused;
    logic [MAX_DEPTH-1:0]       vld_q;
    logic [MAX_DEPTH-1:0]       vld_nxt;
    logic                       chg;
    logic                       evt;
    logic                       out_vld;
    logic [NCH-1:0][WIDTH-1:0]  lane_out;
    state_t                     state;

    // effective delay: 0 behaves as 1, oversize requests saturate
    always_comb begin
        if (dly_q == '0)
            d_cur = DW'(1);
        else if (dly_q > DW'(MAX_DEPTH))
            d_cur = DW'(MAX_DEPTH);
        else
            d_cur = dly_q;
    end

    assign chg = (d_cur != d_prev);
    assign evt = flush | chg;

    // read slot = (wp - D) mod MAX_DEPTH, done by compare so any depth wraps right
    always_comb begin
        if (XW'(wp) >= XW'(d_cur))
            rp_x = XW'(wp) - XW'(d_cur);
        else
            rp_x = XW'(wp) + XW'(MAX_DEPTH) - XW'(d_cur);
    end
    assign rp        = rp_x[AW-1:0];
    assign rp_unused = ^rp_x[XW-1:AW];

    assign wp_nxt = (wp == AW'(MAX_DEPTH - 1)) ? '0 : wp + AW'(1);

    // on a flush/delay change everything in flight dies, but this cycle's sample lands
    always_comb begin
        vld_nxt     = evt ? '0 : vld_q;
        vld_nxt[wp] = bus.in_valid;
    end

    // In the cycle a new delay first takes effect the read slot was filled under
    // the old delay, so the output is suppressed for that one cycle.
    assign out_vld       = vld_q[rp] & ~chg;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = lane_out;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        var_delay_line_lane #(
            .WIDTH     (WIDTH),
            .MAX_DEPTH (MAX_DEPTH),
            .AW        (AW)
        ) u_lane (
            .clk    (clk),
            .wp     (wp),
            .rp     (rp),
            .din    (bus.in_data[c*WIDTH +: WIDTH]),
            .en_out (out_vld),
            .dout   (lane_out[c])
        );
    end

    // pointer, valid bits and delay history; d_prev restarts at the post-reset D of 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp     <= '0;
            vld_q  <= '0;
            dly_q  <= '0;
            d_prev <= DW'(1);
        end else begin
            wp     <= wp_nxt;
            vld_q  <= vld_nxt;
            dly_q  <= dly;
            d_prev <= d_cur;
        end
    end

    // refill window: busy for D cycles after any event, a new event restarts it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (evt) begin
            state <= REFILL;
            cnt   <= d_cur;
            busy  <= 1'b1;
        end else if (state == REFILL) begin
            if (cnt == DW'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt - DW'(1);
            end
        end
    end

`ifdef VAR_DELAY_LINE_CNT_EN
    // saturating count of emitted samples; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_cnt <= '0;
        else if (out_vld && (out_cnt != 32'hFFFF_FFFF))
            out_cnt <= out_cnt + 32'd1;
    end
`else
    // no output counter in this build
`endif
endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboard bench for var_delay_line. Each stimulus cycle is logged into a
// per-cycle history; the expected output for that cycle is derived from the
// history (which earlier sample is due, and whether a reset/flush/delay change
// killed it since) and queued. A monitor pops one entry per cycle and compares.
module tb_var_delay_line;
    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int MAXD  = 6;
    localparam int DW    = $clog2(MAXD + 1);
    localparam int W     = NCH * WIDTH;
    localparam int NCYC  = 2048;

    bit clk;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          flush;
    logic [DW-1:0] dly;
    logic          busy;
`ifdef VAR_DELAY_LINE_CNT_EN
    logic [31:0]   out_cnt;
`endif

    var_delay_line_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    var_delay_line #(.NCH(NCH), .WIDTH(WIDTH), .MAX_DEPTH(MAXD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef VAR_DELAY_LINE_CNT_EN
        .out_cnt (out_cnt),
`endif
        .flush   (flush),
        .dly     (dly),
        .bus     (bus),
        .busy    (busy)
    );

    // stimulus history, indexed by cycle
    bit           iv   [NCYC];
    logic [W-1:0] idat [NCYC];
    bit           fl   [NCYC];
    bit           rs   [NCYC];
    int           dl   [NCYC];

    typedef struct {
        int           cyc;
        bit           v;
        logic [W-1:0] d;
        bit           b;
        int           cnt;
    } exp_t;
    exp_t sb[$];

    int t;
    int errors;
    int checks;
    int run_cnt;

    function automatic int clampd(int q);
        if (q == 0) return 1;
        if (q > MAXD) return MAXD;
        return q;
    endfunction

    // delay in force during cycle tt: the dly seen one cycle earlier (0 after reset)
    function automatic int dcur(int tt);
        if (tt == 0 || rs[tt-1]) return 1;
        return clampd(dl[tt-1]);
    endfunction

    function automatic bit chg(int tt);
        int p;
        if (tt <= 1 || rs[tt-1]) p = 1;
        else p = dcur(tt-1);
        return dcur(tt) != p;
    endfunction

    function automatic bit ev(int tt);
        return !rs[tt] && (fl[tt] || chg(tt));
    endfunction

    // sample from cycle t-D is visible unless something wiped the line since
    function automatic bit exp_valid(int tt);
        int s;
        s = tt - dcur(tt);
        if (s < 0 || chg(tt) || !iv[s]) return 1'b0;
        for (int u = s; u < tt; u++) if (rs[u]) return 1'b0;
        for (int u = s + 1; u < tt; u++) if (ev(u)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_busy(int tt);
        for (int e = tt - 1; e >= 0 && e >= tt - MAXD; e--) begin
            if (rs[e]) return 1'b0;
            if (ev(e)) return (tt - e) <= dcur(e);
        end
        return 1'b0;
    endfunction

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit f,
                       input bit r, input int dv);
        exp_t e;
        if (t >= NCYC) begin
            errors++;
            $display("FAIL history: cycle %0d exceeds table size %0d", t, NCYC);
            return;
        end
        iv[t] = v; idat[t] = d; fl[t] = f; rs[t] = r; dl[t] = dv;
        bus.in_valid = v;
        bus.in_data  = d;
        flush        = f;
        rst_n        = !r;
        dly          = dv[DW-1:0];
        e.cyc = t;
        e.v   = exp_valid(t);
        e.d   = e.v ? idat[t - dcur(t)] : '0;
        e.b   = exp_busy(t);
        e.cnt = run_cnt;
        run_cnt = r ? 0 : run_cnt + int'(e.v);
        sb.push_back(e);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n, input int dv);
        repeat (n) cyc(1'b0, W'($urandom), 1'b0, 1'b0, dv);
    endtask

    task automatic stream(input int n, input int dv);
        repeat (n) cyc(1'b1, W'($urandom), 1'b0, 1'b0, dv);
    endtask

    // monitor: one scoreboard entry per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({bus.out_valid, bus.out_data, busy} !== {e.v, e.d, e.b}) begin
                    errors++;
                    $display("FAIL out cyc%0d: got v=%0b d=%h busy=%0b, want v=%0b d=%h busy=%0b",
                             e.cyc, bus.out_valid, bus.out_data, busy, e.v, e.d, e.b);
                end
`ifdef VAR_DELAY_LINE_CNT_EN
                checks++;
                if (out_cnt !== 32'(e.cnt)) begin
                    errors++;
                    $display("FAIL out_cnt cyc%0d: got %0d, want %0d", e.cyc, out_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        bit            bv [5];
        logic [W-1:0]  bd [5];
        int            cur_d;
        errors = 0; checks = 0; run_cnt = 0;
        rst_n = 1'b0; flush = 1'b0; dly = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        // cycle 0 is the power-on reset edge; outputs are undefined before it
        t = 0; rs[0] = 1'b1; iv[0] = 1'b0; fl[0] = 1'b0; dl[0] = 0; idat[0] = '0;
        @(posedge clk);
        #1;
        t = 1;
        cyc(1'b0, '0, 1'b0, 1'b1, 3);

        // basic latency at dly=3
        idle(8, 3);
        cyc(1'b1, 16'h0102, 1'b0, 1'b0, 3);
        cyc(1'b1, 16'h0304, 1'b0, 1'b0, 3);
        idle(6, 3);

        // clamp (7 -> 6) and pointer wrap with a counting stream
        idle(2, 7);
        for (int i = 0; i <= 20; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, 7);
        idle(8, 7);

        // dly=0 behaves as one register stage
        idle(2, 0);
        stream(10, 0);
        idle(3, 0);

        // bubbles at dly=4
        idle(2, 4);
        bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bd = '{16'h0007, 16'hdead, 16'h0008, 16'h0009, 16'hbeef};
        for (int i = 0; i < 5; i++) cyc(bv[i], bd[i], 1'b0, 1'b0, 4);
        idle(6, 4);

        // delay change 2 -> 6 mid-stream
        idle(2, 2);
        stream(6, 2);
        stream(10, 6);

        // flush with three samples in flight, then flush restarting a refill
        stream(3, 6);
        cyc(1'b0, W'($urandom), 1'b1, 1'b0, 6);
        idle(4, 6);
        cyc(1'b1, W'($urandom), 1'b1, 1'b0, 6);
        stream(3, 6);
        cyc(1'b1, W'($urandom), 1'b1, 1'b0, 6);
        stream(8, 6);

        // flush coinciding with the cycle a new delay takes effect
        cyc(1'b1, W'($urandom), 1'b0, 1'b0, 3);
        cyc(1'b1, W'($urandom), 1'b1, 1'b0, 3);
        stream(6, 3);

        // reset mid-stream, then reset together with flush
        stream(3, 3);
        cyc(1'b1, W'($urandom), 1'b0, 1'b1, 3);
        stream(6, 3);
        cyc(1'b1, W'($urandom), 1'b1, 1'b1, 3);
        stream(6, 3);

        // randomized mix of traffic, flushes, delay changes and resets
        cur_d = 5;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) cur_d = int'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, W'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, cur_d);
        end
        idle(8, cur_d);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
